// File: rtl/trigger_scheduler_if.sv
// Issue-side bundle between the trigger resolvers, the scheduler and the decode stage.
// master: scheduler side (drives the issue register and counters); slave: resolver/decode side.
interface trigger_scheduler_if #(
  parameter int unsigned NUM_TRIGGERS  = 16,
  parameter int unsigned COUNTER_WIDTH = 32
);
  localparam int unsigned IDX_W = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;

  logic                     enable;
  logic [NUM_TRIGGERS-1:0]  trigger_valid;
  logic [NUM_TRIGGERS-1:0]  trigger_updates_state;
  logic                     downstream_ready;
  logic                     issue_valid;
  logic [IDX_W-1:0]         issue_index;
  logic                     issue_hazard;
  logic [COUNTER_WIDTH-1:0] issue_count;
  logic [COUNTER_WIDTH-1:0] hazard_stall_count;

  modport master (
    input  enable, trigger_valid, trigger_updates_state, downstream_ready,
    output issue_valid, issue_index, issue_hazard, issue_count, hazard_stall_count
  );

  modport slave (
    output enable, trigger_valid, trigger_updates_state, downstream_ready,
    input  issue_valid, issue_index, issue_hazard, issue_count, hazard_stall_count
  );
endinterface

// File: rtl/trigger_scheduler.sv
// Picks one eligible trigger per cycle into the issue register, blocking issue for a hazard window
// after state-updating triggers. Define TIA_ROUND_ROBIN_SCHEDULING_EN for rotating priority.
module trigger_scheduler #(
  parameter int unsigned NUM_TRIGGERS  = 16,
  parameter int unsigned HAZARD_WINDOW = 1,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  trigger_scheduler_if.master bus
);
  localparam int unsigned IDX_W = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;
  localparam int unsigned WIN_W = (HAZARD_WINDOW > 1) ? $clog2(HAZARD_WINDOW + 1) : 1;

  typedef enum logic {StReady, StBlocked} state_e;

  state_e                   state_q;
  logic [WIN_W-1:0]         win_q;
  logic                     issue_valid_q;
  logic [IDX_W-1:0]         issue_index_q;
  logic                     issue_hazard_q;
  logic [COUNTER_WIDTH-1:0] issue_count_q;
  logic [COUNTER_WIDTH-1:0] stall_count_q;

  logic             accept;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             window_open;
  logic             hazard_hold;
  logic             load;

  assign accept = issue_valid_q & bus.downstream_ready;

`ifdef TIA_ROUND_ROBIN_SCHEDULING_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] base;

  assign ptr_next = (issue_index_q == IDX_W'(NUM_TRIGGERS - 1)) ? '0 : issue_index_q + IDX_W'(1);
  // Search from the pointer as it will stand after this edge, so back-to-back issue rotates.
  assign base     = accept ? ptr_next : ptr_q;

  always_comb begin
    int unsigned j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_TRIGGERS; i++) begin
      j = i + {{(32 - IDX_W){1'b0}}, base};
      if (j >= NUM_TRIGGERS) j = j - NUM_TRIGGERS;
      if (!sel_found && bus.trigger_valid[j[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = j[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_next;
    end
  end
`else
  always_comb begin
    sel_found = |bus.trigger_valid;
    sel_idx   = '0;
    for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
      if (bus.trigger_valid[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  // The last window cycle already permits a load, so the first reissue lands HAZARD_WINDOW
  // edges after the accepting edge.
  assign window_open = (state_q == StReady) || (win_q == WIN_W'(1));
  assign hazard_hold = issue_valid_q & issue_hazard_q & (HAZARD_WINDOW != 0);
  assign load        = bus.enable & sel_found & window_open &
                       (!issue_valid_q | bus.downstream_ready) & !hazard_hold;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StReady;
      win_q          <= '0;
      issue_valid_q  <= 1'b0;
      issue_index_q  <= '0;
      issue_hazard_q <= 1'b0;
      issue_count_q  <= '0;
      stall_count_q  <= '0;
    end else begin
      if (load) begin
        issue_valid_q  <= 1'b1;
        issue_index_q  <= sel_idx;
        issue_hazard_q <= bus.trigger_updates_state[sel_idx];
      end else if (accept) begin
        issue_valid_q  <= 1'b0;
      end

      unique case (state_q)
        StReady: begin
          if ((HAZARD_WINDOW != 0) && accept && issue_hazard_q) begin
            state_q <= StBlocked;
            win_q   <= WIN_W'(HAZARD_WINDOW);
          end
        end
        StBlocked: begin
          win_q <= win_q - WIN_W'(1);
          if (win_q == WIN_W'(1)) state_q <= StReady;
        end
        default: state_q <= StReady;
      endcase

      if (accept) issue_count_q <= issue_count_q + COUNTER_WIDTH'(1);
      if ((state_q == StBlocked) && |bus.trigger_valid) begin
        stall_count_q <= stall_count_q + COUNTER_WIDTH'(1);
      end
    end
  end

  assign bus.issue_valid        = issue_valid_q;
  assign bus.issue_index        = issue_index_q;
  assign bus.issue_hazard       = issue_hazard_q;
  assign bus.issue_count        = issue_count_q;
  assign bus.hazard_stall_count = stall_count_q;
endmodule
